// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DW_BYTES = 8;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  // Request captured at acceptance and held until the response is consumed.
  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    size_e       size;
    logic [63:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake between datapath and memory.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_merge.sv
// dmem_lane_merge: byte-lane mask and store-data merge for one doubleword.
// DMEM_ALIGN_CHECK_EN: when defined, misaligned half/word/double accesses
// raise misalign; otherwise the offset is rounded down to natural alignment.
module dmem_lane_merge import dmem_pkg::*; (
  input  size_e       size,
  input  logic [2:0]  ofs,
  input  logic [63:0] wdata,
  input  logic [63:0] old,
  output logic [63:0] mask,
  output logic [63:0] merged,
  output logic        misalign
);

  logic [2:0]          eofs;
  logic [DW_BYTES-1:0] be_base;
  logic [DW_BYTES-1:0] be;
  logic [63:0]         wsh;

  // Byte enables and lane-shifted store data; offset rounded to the size.
  always_comb begin
    be_base = '1;
    eofs    = 3'd0;
    case (size)
      SZ_B:    begin be_base = 8'h01; eofs = ofs;               end
      SZ_H:    begin be_base = 8'h03; eofs = {ofs[2:1], 1'b0};  end
      SZ_W:    begin be_base = 8'h0F; eofs = {ofs[2], 2'b00};   end
      default: begin be_base = 8'hFF; eofs = 3'd0;              end
    endcase
    be  = be_base << eofs;
    wsh = wdata << {eofs, 3'b000};
  end

  for (genvar b = 0; b < DW_BYTES; b++) begin : g_lane
    assign mask[8*b +: 8]   = {8{be[b]}};
    assign merged[8*b +: 8] = be[b] ? wsh[8*b +: 8] : old[8*b +: 8];
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Any offset bit below the access size makes the access misaligned.
  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = ofs[0];
      SZ_W:    misalign = |ofs[1:0];
      SZ_D:    misalign = |ofs;
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: latency-configurable data-memory responder. One request
// outstanding; IDLE -> WAIT (WAIT cycles) -> ACCESS -> RESP -> IDLE.
// DMEM_ALIGN_CHECK_EN (in dmem_lane_merge) turns misalignment into a fault.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_e      state_q, state_d;
  req_t        req_q;
  logic [3:0]  cnt_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem [DEPTH];

  logic          accept;
  logic [AW-1:0] idx;
  logic          oor;
  logic          misalign;
  logic          fault;
  logic [63:0]   old;
  logic [63:0]   mask;
  logic [63:0]   merged;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign idx    = req_q.addr[3 +: AW];
  assign oor    = |req_q.addr[63:3+AW];
  assign fault  = oor | misalign;
  assign old    = mem[idx];

  dmem_lane_merge u_merge (
    .size     (req_q.size),
    .ofs      (req_q.addr[2:0]),
    .wdata    (req_q.wdata),
    .old      (old),
    .mask     (mask),
    .merged   (merged),
    .misalign (misalign)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (bus.req_valid) state_d = (WAIT > 0) ? dmem_pkg::WAIT : ACCESS;
      dmem_pkg::WAIT: if (cnt_q == 4'd0) state_d = ACCESS;
      ACCESS:         state_d = RESP;
      RESP:           if (bus.rsp_ready) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q.we    <= bus.req_we;
        req_q.addr  <= bus.req_addr;
        req_q.size  <= size_e'(bus.req_size);
        req_q.wdata <= bus.req_wdata;
        cnt_q       <= CNT_INIT;
      end else if (state_q == dmem_pkg::WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Loads and stores both return the pre-access doubleword.
      if (state_q == ACCESS) begin
        rdata_q <= fault ? 64'd0 : old;
        err_q   <= fault;
      end
    end
  end

  // Storage write: only lanes selected by the mask change; faults never write.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && req_q.we && !fault)
      mem[idx] <= (old & ~mask) | (merged & mask);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
module tb_dmem_responder;
  localparam int DEPTH_C = 256;
  localparam int WAIT_C  = 2;
  localparam int AW      = $clog2(DEPTH_C);

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    bit          cd;     // rdata known to the model
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t        sb[$];
  logic [63:0] mdl   [DEPTH_C];
  bit          known [DEPTH_C];

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH_C), .WAIT(WAIT_C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte-by-byte update of a doubleword array.
  task automatic push_exp(input bit we, input logic [63:0] addr, input logic [1:0] size,
                          input logic [63:0] wd);
    exp_t        e;
    int          nb, base, idx;
    bit          flt;
    logic [63:0] w;
    nb   = 1 << size;
    flt  = (addr >> (3 + AW)) != 64'd0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((int'(addr[2:0]) % nb) != 0) flt = 1'b1;
`endif
    base = (int'(addr[2:0]) / nb) * nb;
    idx  = int'(addr[3 +: AW]);
    if (flt) begin
      e.rdata = 64'd0; e.err = 1'b1; e.cd = 1'b1;
    end else begin
      e.rdata = mdl[idx]; e.err = 1'b0; e.cd = known[idx];
      if (we) begin
        w = mdl[idx];
        for (int i = 0; i < nb; i++) w[8*(base+i) +: 8] = wd[8*i +: 8];
        mdl[idx] = w;
        if (nb == 8) known[idx] = 1'b1;
      end
    end
    sb.push_back(e);
  endtask

  // One request/response; hold = cycles rsp_ready stays low (0 = tied high).
  task automatic run_req(input bit we, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wd, input int hold);
    int          n;
    exp_t        e;
    logic [63:0] r0;
    logic        e0;
    @(negedge clk);
    push_exp(we, addr, size, wd);
    bus.req_we = we; bus.req_addr = addr; bus.req_size = size; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin chk("accept_timeout", 0, 1); bus.req_valid = 1'b0; void'(sb.pop_front()); return; end
    @(negedge clk);             // acceptance edge has passed
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin chk("rsp_timeout", 0, 1); void'(sb.pop_front()); return; end
    chk("latency", 64'(n), 64'(WAIT_C + 1));
    e = sb.pop_front();
    chk("rsp_err", bus.rsp_err, e.err);
    if (e.cd) chk("rsp_rdata", bus.rsp_rdata, e.rdata);
    r0 = bus.rsp_rdata; e0 = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_rdata", bus.rsp_rdata, r0);
      chk("hold_err", bus.rsp_err, e0);
      chk("hold_ready_low", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_consumed", bus.rsp_valid, 0);
    chk("back_idle", bus.req_ready, 1);
    bus.rsp_ready = 1'b0;
  endtask

  // Accept a store, then reset while it waits; the store must vanish.
  task automatic abort_store(input logic [63:0] addr, input logic [63:0] wd);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = addr; bus.req_size = 2'd3; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_busy", bus.req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rsp_rdata", bus.rsp_rdata, 0);
    chk("abort_rsp_err", bus.rsp_err, 0);
    chk("abort_req_ready", bus.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH_C; i++) begin mdl[i] = 64'd0; known[i] = 1'b0; end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 64'd0;
    bus.req_size = 2'd0; bus.req_wdata = 64'd0; bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst_n = 1'b1;

    // Double store then load.
    run_req(1'b1, 64'h10, 2'd3, 64'h1122334455667788, 1);
    run_req(1'b0, 64'h10, 2'd3, 64'd0, 1);
    // Byte lane 3.
    run_req(1'b1, 64'h13, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 1);
    run_req(1'b0, 64'h10, 2'd3, 64'd0, 1);
    chk("byte_model", mdl[2], 64'h11223344AB667788);
    // Upper word of 0x18.
    run_req(1'b1, 64'h18, 2'd3, 64'h0123456789ABCDEF, 1);
    run_req(1'b1, 64'h1C, 2'd2, 64'hDEADBEEF, 1);
    run_req(1'b0, 64'h18, 2'd3, 64'd0, 1);
    chk("word_model", mdl[3], 64'hDEADBEEF89ABCDEF);
    // Out of range, response stalled 5 cycles.
    run_req(1'b0, 64'(DEPTH_C * 8), 2'd3, 64'd0, 5);
    // Misaligned half store.
    run_req(1'b1, 64'h20, 2'd3, 64'h0, 1);
    run_req(1'b1, 64'h21, 2'd1, 64'hCAFE, 1);
    run_req(1'b0, 64'h20, 2'd3, 64'd0, 1);
    // rsp_ready tied high: one-cycle responses back to back.
    run_req(1'b0, 64'h10, 2'd3, 64'd0, 0);
    run_req(1'b0, 64'h18, 2'd2, 64'd0, 0);

    // Random mix over the first eight doublewords.
    for (int i = 0; i < 8; i++) run_req(1'b1, 64'(i * 8), 2'd3, {$urandom, $urandom}, 0);
    for (int i = 0; i < 24; i++)
      run_req(1'($urandom_range(0, 1)), 64'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
              {$urandom, $urandom}, $urandom_range(0, 2));

    // Reset during WAIT discards the store.
    abort_store(64'h10, 64'h5555_AAAA_5555_AAAA);
    run_req(1'b0, 64'h10, 2'd3, 64'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the processor's data-memory port. Accepts one load or store request at a time from the multicycle datapath (address from the ALU-out register, store data from register B), then waits a configurable number of cycles. It performs a byte-lane-merged access on an internal doubleword array and returns a registered response through a valid/ready handshake. It replaces the zero-wait data memory so the control unit can be exercised against real memory latency.

## Interface
- DEPTH, 256: storage size in 64-bit doublewords; power of two.
- WAIT, 2: wait cycles between request acceptance and the access; range 0..15.
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_wdata  in  64  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  datapath consumes the response.
- rsp_rdata  out  64  full aligned doubleword at the request address; the datapath does the extraction and extension.
- rsp_err  out  1  access faulted; no store was performed.

## Operation
- States are IDLE, WAIT, ACCESS and RESP.
- IDLE: a request is accepted when req_valid and req_ready are both high on a rising edge. On acceptance, we, addr, size and wdata are latched into internal registers.
  - WAIT > 0: next state is WAIT.
  - WAIT = 0: next state is ACCESS.
- WAIT: a 4-bit counter loads WAIT-1 on entry and decrements each cycle. The state moves to ACCESS when the counter reaches 0.
- ACCESS: lasts exactly one cycle.
  - The doubleword index is addr[3+log2(DEPTH)-1:3]. The index is out of range when any of addr[63:3+log2(DEPTH)] is nonzero.
  - Load: rsp_rdata is registered from the array.
  - Store: the new doubleword is built as mem & ~mask | (shifted wdata & mask) and written back. rsp_rdata is registered as the pre-store value.
  - Lane mask for byte size: 0xFF << 8*addr[2:0].
  - Lane mask for half size: 0xFFFF << 16*addr[2:1].
  - Lane mask for word size: 0xFFFFFFFF << 32*addr[2].
  - Lane mask for double size: all ones.
  - Fault (out-of-range, or misaligned when the check is enabled): rsp_err is set, no write occurs, and rsp_rdata is set to 0.
  - Next state is RESP.
- RESP: rsp_valid is held high, and rsp_rdata and rsp_err are held stable until rsp_ready is high on an edge. The state then returns to IDLE.
- No new request is accepted until the response has been consumed. Only one request is outstanding at a time.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
  - Array contents are not reset.
- Latency: if acceptance happens at edge 0, rsp_valid rises after edge WAIT+1.
  - WAIT = 2: rsp_valid is first high in the cycle after edge 3.
- rsp_valid is already high in the same cycle rsp_ready is sampled, so back-to-back requests reach a throughput of one per WAIT+3 cycles.
- Reset asserted mid-operation: the FSM aborts to IDLE immediately and the latched request is discarded.
  - Before ACCESS, a pending store is never written.
  - After ACCESS, the write stands.
- req_valid held high while in RESP has no effect until the state is back in IDLE.
- rsp_ready held permanently high: the response lasts exactly one cycle.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: misaligned requests fault with rsp_err = 1 and no store. Misaligned means:
  - half with addr[0] ≠ 0;
  - word with addr[1:0] ≠ 0;
  - double with addr[2:0] ≠ 0.
- DMEM_ALIGN_CHECK_EN not defined: the low address bits below the access size are ignored, forcing natural alignment. Misalignment is never an error.

## Structure
- dmem_pkg holds:
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the state enum (IDLE, WAIT, ACCESS, RESP);
  - the doubleword byte-width constant.
- Sub-module dmem_lane_merge is combinational. Inputs are size, addr[2:0], wdata and old data; outputs are the lane mask, the merged doubleword and the misaligned flag. It is instantiated once.

## Test plan
- Store double 0x1122334455667788 to addr 0x10, then load addr 0x10. Required: rsp_rdata = 0x1122334455667788, rsp_err = 0, rsp_valid rises WAIT+1 edges after acceptance.
- After the first scenario, store byte 0xAB to addr 0x13, then load 0x10. Required: 0x11223344AB667788.
- Store word 0xDEADBEEF to 0x1C (upper word), then load 0x18. Required: upper 32 bits = 0xDEADBEEF, lower 32 bits unchanged.
- Load addr DEPTH*8. Required: rsp_err = 1, rsp_rdata = 0. Hold rsp_ready low for 5 cycles; rsp_valid must stay high and the outputs stable throughout.
- Store half to 0x21:
  - with DMEM_ALIGN_CHECK_EN: rsp_err = 1, memory unchanged;
  - without it: the store lands at 0x20 with rsp_err = 0.
- Accept a store, then drop Reset during WAIT. Required: all outputs return to their reset values, req_ready = 1, and a following load shows the old data.
